// File: rtl/ram_rd_pkg.sv
// Shared types and default widths for the RAM burst stream reader.
package ram_rd_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ram_stream_reader.sv
// Reads a burst of words from a combinational-read RAM and presents them on a valid/ready stream.
// Define RD_CHECKSUM_EN to build the per-burst byte-sum accumulator; otherwise checksum is tied to 0.
//
// state  | meaning
// IDLE   | waiting for start; base/len sampled here
// LOAD   | first RAM word captured into out_data
// STREAM | presenting words; advance on each out_valid & out_ready
// DONE   | one-cycle done pulse, then back to IDLE
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] adress,
    input  logic [DATA_W-1:0] Q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] REM_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] remaining;
    logic            xfer;

    assign xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (xfer && (remaining == REM_ONE)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // remaining counts words still to be transferred, including the one on out_data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adress    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        adress    <= base;
                        remaining <= (len == '0) ? REM_FULL : {1'b0, len};
                    end
                end
                LOAD: begin
                    out_data  <= Q;
                    out_valid <= 1'b1;
                    adress    <= adress + 1'b1;
                end
                STREAM: begin
                    if (xfer) begin
                        if (remaining > REM_ONE) begin
                            out_data  <= Q;
                            adress    <= adress + 1'b1;
                            remaining <= remaining - 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            remaining <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RD_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= '0;
        end else if ((state == IDLE) && start) begin
            csum <= '0;
        end else if ((state == STREAM) && xfer) begin
            csum <= csum + out_data;
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule
